reg_pipe: RTL and testbench
===========================

// Module: reg_pipe
// PURPOSE
//  Parametrised multi-bit, multi-stage register pipeline with valid/ready handshake.
//  Next generation of the single-bit D flip-flop: adds WIDTH, depth, back-pressure, flush and occupancy.
//  Each stage is a full-throughput skid-buffered slice, so no combinational path runs from ready_i to ready_o.
//  Used to retime long datapaths between producer/consumer blocks without losing throughput.
// PARAMETERS
//  WIDTH    8      data bits per beat (>=1)
//  STAGES   2      number of register slices in series (>=1); min latency = STAGES cycles
//  RST_VAL  '0     value loaded into every data register on reset/flush (WIDTH bits)
// PORTS
//  clk_i     in   1              clock, all logic on rising edge
//  rst_n_i   in   1              reset, synchronous, active-low
//  flush_i   in   1              sync clear of all in-flight beats
//  valid_i   in   1              producer beat valid
//  ready_o   out  1              pipe can accept a beat
//  data_i    in   WIDTH          producer data
//  valid_o   out  1              consumer beat valid
//  ready_i   in   1              consumer accepts beat
//  data_o    out  WIDTH          consumer data
//  count_o   out  CNT_W          beats currently held, CNT_W = $clog2(2*STAGES+1)
// BEHAVIOUR
//  - Transfer occurs on an edge where valid && ready on that interface (in: valid_i&ready_o; out: valid_o&ready_i).
//  - Reset (rst_n_i==0 at edge): every slice EMPTY, data/skid regs = RST_VAL, count_o=0, valid_o=0.
//    ready_o is gated to 0 while rst_n_i==0; ready_o=1 in the first cycle after release.
//  - Slice FSM (one per stage, states EMPTY/ONE/FULL; main reg + skid reg):
//    EMPTY: in-xfer -> ONE (load main).
//    ONE:   in-xfer & !out-xfer -> FULL (load skid); out-xfer & !in-xfer -> EMPTY;
//           both -> ONE (main <= new data).
//    FULL:  out-xfer -> ONE (main <= skid); no in-xfer possible.
//    slice ready = (state != FULL), taken from state flop only; slice valid = (state != EMPTY).
//  - Slices chained: slice k out drives slice k+1 in; first slice in = pipe in, last slice out = pipe out.
//  - Unstalled latency: beat accepted at edge N appears on data_o/valid_o after edge N+STAGES-1, i.e.
//    visible in cycle N+STAGES. Throughput 1 beat/cycle when ready_i held 1.
//  - Capacity 2*STAGES beats; ready_o drops only when slice 0 is FULL.
//  - count_o: +1 on in-xfer, -1 on out-xfer, unchanged on both/neither; registered; never exceeds 2*STAGES.
//  - valid_o and data_o stable while valid_o=1 and ready_i=0 (AXI-style hold); data_o = main reg of last slice.
//  - When valid_o=0, data_o holds its last value (RST_VAL after reset/flush); consumers must not sample it.
//  - flush_i=1 at an edge: all slices -> EMPTY, data regs = RST_VAL, count_o=0; any in-xfer or out-xfer
//    in that cycle is discarded (producer/consumer see ready/valid but beat is dropped by contract).
//  - Reset has priority over flush; flush over handshake.
//  - Order preserved: beats leave in acceptance order, none duplicated or lost (except by flush/reset).
// STRUCTURE
//  - Package reg_pipe_pkg: typedef enum logic [1:0] {SLICE_EMPTY, SLICE_ONE, SLICE_FULL} slice_state_e;
//    function cnt_w(stages) returning $clog2(2*stages+1).
//  - Sub-module reg_slice (WIDTH, RST_VAL): one skid-buffered stage with the FSM above plus flush input.
//  - reg_pipe: generate-loop of STAGES reg_slice instances, handshake chaining, count_o counter.
// TESTING
//  1. Reset: hold rst_n_i=0 3 cycles with valid_i=1, data_i=8'hA5 -> valid_o=0, ready_o=0, count_o=0,
//     data_o=RST_VAL; after release ready_o=1.
//  2. Stream: STAGES=2, ready_i=1, push 8'h01..8'h10 back-to-back -> 8'h01 on valid_o in cycle 2 after accept,
//     then one beat/cycle in order, count_o steady at 2.
//  3. Back-pressure: ready_i=0, push continuously -> exactly 4 beats accepted, ready_o=0, count_o=4,
//     data_o holds first beat; raise ready_i -> all 4 drained in order, no loss/duplication.
//  4. Simultaneous in/out on FULL-1 state: count_o=3, valid_i=1 & ready_i=1 -> count_o stays 3, order kept.
//  5. Flush mid-stream with count_o=3 and valid_i=1 -> next cycle valid_o=0, count_o=0, data_o=RST_VAL,
//     flush-cycle input beat not emitted; subsequent push 8'h5A emerges after STAGES cycles.
//  6. Random valid_i/ready_i (10k cycles, WIDTH=32, STAGES=1 and 4) vs scoreboard queue: order, count_o
//     matches queue size, ready_o never depends combinationally on ready_i.

Source files
------------

// File: rtl/reg_pipe_pkg.sv
// Shared types and helpers for the reg_pipe retiming pipeline.
// Slice occupancy states and the occupancy-counter width function.
package reg_pipe_pkg;

  typedef enum logic [1:0] {
    SLICE_EMPTY = 2'd0,
    SLICE_ONE   = 2'd1,
    SLICE_FULL  = 2'd2
  } slice_state_e;

  // Counter must hold 0..2*stages inclusive.
  function automatic int unsigned cnt_w(input int unsigned stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/reg_slice.sv
// One skid-buffered valid/ready register slice: main reg drives the output,
// skid reg catches the beat arriving while the consumer stalls.
module reg_slice
  import reg_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  slice_state_e     r_state;
  slice_state_e     w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Ready comes straight from the state flop, breaking the ready_i->ready_o path.
  assign ready_o    = (r_state != SLICE_FULL);
  assign valid_o    = (r_state != SLICE_EMPTY);
  assign data_o     = r_main;
  assign w_in_xfer  = valid_i & ready_o;
  assign w_out_xfer = valid_o & ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      SLICE_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = SLICE_ONE;
          w_main_nxt  = data_i;
        end
      end
      SLICE_ONE: begin
        if (w_in_xfer && !w_out_xfer) begin
          w_state_nxt = SLICE_FULL;
          w_skid_nxt  = data_i;
        end else if (w_out_xfer && !w_in_xfer) begin
          w_state_nxt = SLICE_EMPTY;
        end else if (w_in_xfer && w_out_xfer) begin
          w_main_nxt = data_i;
        end
      end
      SLICE_FULL: begin
        if (w_out_xfer) begin
          w_state_nxt = SLICE_ONE;
          w_main_nxt  = r_skid;
        end
      end
      default: w_state_nxt = SLICE_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      r_state <= SLICE_EMPTY;
      r_main  <= RST_VAL;
      r_skid  <= RST_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

endmodule

// File: rtl/reg_pipe.sv
// Parametrised multi-stage valid/ready register pipeline built from skid slices,
// with synchronous flush and a registered occupancy count.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [cnt_w(STAGES)-1:0]   count_o
);

  localparam int unsigned      CNT_W = cnt_w(STAGES);
  localparam logic [CNT_W-1:0] CNT_1 = CNT_W'(1);
  localparam logic [CNT_W-1:0] CAP   = CNT_W'(2 * STAGES);

  // Index k is the input side of slice k; index STAGES is the pipe output.
  logic [STAGES:0]  w_valid;
  logic [STAGES:0]  w_ready;
  logic [WIDTH-1:0] w_data [STAGES+1];
  logic [CNT_W-1:0] r_count;
  logic             w_in_xfer;
  logic             w_out_xfer;

  assign w_valid[0]      = valid_i;
  assign w_data[0]       = data_i;
  assign w_ready[STAGES] = ready_i;

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_slice
      reg_slice #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_slice (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .valid_i (w_valid[g]),
        .ready_o (w_ready[g]),
        .data_i  (w_data[g]),
        .valid_o (w_valid[g+1]),
        .ready_i (w_ready[g+1]),
        .data_o  (w_data[g+1])
      );
    end
  endgenerate

  assign ready_o    = w_ready[0] & rst_n_i;
  assign valid_o    = w_valid[STAGES];
  assign data_o     = w_data[STAGES];
  assign w_in_xfer  = valid_i & ready_o;
  assign w_out_xfer = valid_o & ready_i;
  assign count_o    = r_count;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      r_count <= '0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + CNT_1;
        2'b01:   r_count <= r_count - CNT_1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_count_cap: assert property (@(posedge clk_i) disable iff (!rst_n_i) r_count <= CAP);

  a_out_hold: assert property (@(posedge clk_i)
    (rst_n_i && !flush_i && valid_o && !ready_i) |=> (valid_o && $stable(data_o)));

endmodule

// File: tb/tb_reg_pipe.sv
// Bench for reg_pipe: directed vector table and stream sequence on an 8-bit,
// 2-stage pipe, then randomized traffic on 32-bit 1- and 4-stage pipes vs a queue model.
`timescale 1ns/1ps
module tb_reg_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Directed DUT: WIDTH=8, STAGES=2, RST_VAL=0
  logic       d_rst_n = 1'b0;
  logic       d_flush = 1'b0;
  logic       d_valid = 1'b0;
  logic [7:0] d_data  = '0;
  logic       d_ready = 1'b0;
  logic       d_ready_o, d_valid_o;
  logic [7:0] d_data_o;
  logic [2:0] d_count;

  reg_pipe #(.WIDTH(8), .STAGES(2), .RST_VAL(8'h00)) u_dir (
    .clk_i(clk), .rst_n_i(d_rst_n), .flush_i(d_flush), .valid_i(d_valid),
    .ready_o(d_ready_o), .data_i(d_data), .valid_o(d_valid_o), .ready_i(d_ready),
    .data_o(d_data_o), .count_o(d_count)
  );

  // Random DUTs: index 0 -> STAGES=1, index 1 -> STAGES=4
  localparam logic [31:0] RV0 = 32'hDEAD_BEEF;
  localparam logic [31:0] RV1 = 32'h1234_5678;
  logic        r_rst_n = 1'b0;
  logic [1:0]  r_flush = '0;
  logic [1:0]  r_valid = '0;
  logic [1:0]  r_ready = '0;
  logic [31:0] r_data [2];
  logic [1:0]  r_ready_o, r_valid_o;
  logic [31:0] r_data_o [2];
  logic [1:0]  cnt1;
  logic [3:0]  cnt4;
  logic [3:0]  w_cnt [2];
  assign w_cnt[0] = {2'b00, cnt1};
  assign w_cnt[1] = cnt4;

  reg_pipe #(.WIDTH(32), .STAGES(1), .RST_VAL(RV0)) u_r1 (
    .clk_i(clk), .rst_n_i(r_rst_n), .flush_i(r_flush[0]), .valid_i(r_valid[0]),
    .ready_o(r_ready_o[0]), .data_i(r_data[0]), .valid_o(r_valid_o[0]), .ready_i(r_ready[0]),
    .data_o(r_data_o[0]), .count_o(cnt1)
  );

  reg_pipe #(.WIDTH(32), .STAGES(4), .RST_VAL(RV1)) u_r4 (
    .clk_i(clk), .rst_n_i(r_rst_n), .flush_i(r_flush[1]), .valid_i(r_valid[1]),
    .ready_o(r_ready_o[1]), .data_i(r_data[1]), .valid_o(r_valid_o[1]), .ready_i(r_ready[1]),
    .data_o(r_data_o[1]), .count_o(cnt4)
  );

  typedef struct {
    logic       chk;
    logic       rst_n, flush, valid;
    logic [7:0] data;
    logic       ready;
    logic       ro, vo;
    logic [7:0] dout;
    logic [2:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic chk, input logic rst_n, input logic flush,
                              input logic valid, input logic [7:0] data, input logic ready,
                              input logic ro, input logic vo, input logic [7:0] dout,
                              input logic [2:0] cnt);
    vec_t v;
    v.chk = chk; v.rst_n = rst_n; v.flush = flush; v.valid = valid; v.data = data;
    v.ready = ready; v.ro = ro; v.vo = vo; v.dout = dout; v.cnt = cnt;
    return v;
  endfunction

  localparam int NV = 25;
  vec_t tbl [NV];

  logic [31:0] q [2][$];
  int unsigned stall [2];
  int unsigned stg [2];
  logic [31:0] rv [2];
  logic [1:0]  prev_fl;
  logic [1:0]  in_x, out_x;
  logic [1:0]  ro_snap;
  int unsigned vp, rp;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Outputs are checked in the cycle the inputs are applied (state after the previous edge).
    //            chk rst fl  v  data  rdy | ro vo dout cnt
    tbl[0]  = mk(0, 0, 0, 1, 8'hA5, 0,  0, 0, 8'h00, 0);
    tbl[1]  = mk(1, 0, 0, 1, 8'hA5, 0,  0, 0, 8'h00, 0);
    tbl[2]  = mk(1, 0, 0, 1, 8'hA5, 0,  0, 0, 8'h00, 0);
    tbl[3]  = mk(1, 1, 0, 0, 8'h00, 0,  1, 0, 8'h00, 0);
    tbl[4]  = mk(1, 1, 0, 1, 8'h01, 1,  1, 0, 8'h00, 0);
    tbl[5]  = mk(1, 1, 0, 1, 8'h02, 1,  1, 0, 8'h00, 1);
    tbl[6]  = mk(1, 1, 0, 1, 8'h03, 1,  1, 1, 8'h01, 2);
    tbl[7]  = mk(1, 1, 0, 1, 8'h04, 1,  1, 1, 8'h02, 2);
    tbl[8]  = mk(1, 1, 0, 0, 8'h00, 0,  1, 1, 8'h03, 2);
    tbl[9]  = mk(1, 1, 0, 1, 8'h11, 0,  1, 1, 8'h03, 2);
    tbl[10] = mk(1, 1, 0, 1, 8'h12, 0,  1, 1, 8'h03, 3);
    tbl[11] = mk(1, 1, 0, 1, 8'h13, 0,  0, 1, 8'h03, 4);
    tbl[12] = mk(1, 1, 0, 1, 8'h13, 1,  0, 1, 8'h03, 4);
    tbl[13] = mk(1, 1, 0, 1, 8'h13, 1,  0, 1, 8'h04, 3);
    tbl[14] = mk(1, 1, 0, 1, 8'h13, 1,  1, 1, 8'h11, 2);
    tbl[15] = mk(1, 1, 0, 1, 8'h14, 0,  1, 1, 8'h12, 2);
    tbl[16] = mk(1, 1, 0, 1, 8'h15, 1,  1, 1, 8'h12, 3);
    tbl[17] = mk(1, 1, 0, 1, 8'h16, 0,  0, 1, 8'h13, 3);
    tbl[18] = mk(1, 1, 1, 1, 8'h77, 1,  1, 1, 8'h13, 3);
    tbl[19] = mk(1, 1, 0, 1, 8'h5A, 1,  1, 0, 8'h00, 0);
    tbl[20] = mk(1, 1, 0, 0, 8'h00, 1,  1, 0, 8'h00, 1);
    tbl[21] = mk(1, 1, 0, 0, 8'h00, 1,  1, 1, 8'h5A, 1);
    tbl[22] = mk(1, 1, 0, 0, 8'h00, 1,  1, 0, 8'h5A, 0);
    tbl[23] = mk(1, 0, 1, 1, 8'h99, 1,  0, 0, 8'h5A, 0);
    tbl[24] = mk(1, 1, 0, 0, 8'h00, 0,  1, 0, 8'h00, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      d_rst_n = tbl[i].rst_n; d_flush = tbl[i].flush; d_valid = tbl[i].valid;
      d_data  = tbl[i].data;  d_ready = tbl[i].ready;
      #1;
      if (tbl[i].chk) begin
        check($sformatf("vec%0d.ready_o", i), 32'(d_ready_o), 32'(tbl[i].ro));
        check($sformatf("vec%0d.valid_o", i), 32'(d_valid_o), 32'(tbl[i].vo));
        check($sformatf("vec%0d.data_o", i),  32'(d_data_o),  32'(tbl[i].dout));
        check($sformatf("vec%0d.count_o", i), 32'(d_count),   32'(tbl[i].cnt));
      end
    end

    // Back-to-back stream of 16 beats with the consumer always ready
    for (int c = 0; c <= 18; c++) begin
      int acc, emit;
      @(negedge clk);
      d_flush = 1'b0; d_ready = 1'b1;
      d_valid = (c < 16);
      d_data  = 8'(c + 1);
      #1;
      acc  = (c < 16) ? c : 16;
      emit = (c > 2) ? ((c - 2 < 16) ? c - 2 : 16) : 0;
      check($sformatf("stream%0d.count_o", c), 32'(d_count), 32'(acc - emit));
      check($sformatf("stream%0d.valid_o", c), 32'(d_valid_o), 32'(c >= 2 && c <= 17));
      check($sformatf("stream%0d.ready_o", c), 32'(d_ready_o), 32'd1);
      if (c >= 2 && c <= 17)
        check($sformatf("stream%0d.data_o", c), 32'(d_data_o), 32'(c - 1));
    end
    d_valid = 1'b0;

    // Randomized traffic against a FIFO model of capacity 2*STAGES
    stg[0] = 1; stg[1] = 4; rv[0] = RV0; rv[1] = RV1;
    stall[0] = 0; stall[1] = 0; prev_fl = '0;
    r_data[0] = '0; r_data[1] = '0;
    repeat (3) @(negedge clk);
    r_rst_n = 1'b1;
    vp = 70; rp = 50;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      if (cyc % 500 == 0) begin
        vp = $urandom_range(20, 100);
        rp = $urandom_range(10, 100);
      end
      for (int j = 0; j < 2; j++) begin
        r_flush[j] = ($urandom_range(0, 199) == 0);
        r_valid[j] = ($urandom_range(0, 99) < vp);
        r_ready[j] = ($urandom_range(0, 99) < rp);
        r_data[j]  = $urandom;
      end
      #1;
      for (int j = 0; j < 2; j++) begin
        check($sformatf("rnd%0d.s%0d.count_o", cyc, stg[j]), 32'(w_cnt[j]), 32'(q[j].size()));
        if (q[j].size() == 0)
          check($sformatf("rnd%0d.s%0d.valid_o_empty", cyc, stg[j]), 32'(r_valid_o[j]), 32'd0);
        else if (r_valid_o[j])
          check($sformatf("rnd%0d.s%0d.data_o", cyc, stg[j]), r_data_o[j], q[j][0]);
        if (q[j].size() == 2 * stg[j])
          check($sformatf("rnd%0d.s%0d.ready_o_full", cyc, stg[j]), 32'(r_ready_o[j]), 32'd0);
        if (prev_fl[j])
          check($sformatf("rnd%0d.s%0d.data_o_flushed", cyc, stg[j]), r_data_o[j], rv[j]);
        if (q[j].size() > 0 && !r_valid_o[j]) stall[j]++;
        else stall[j] = 0;
        check($sformatf("rnd%0d.s%0d.latency_exceeded", cyc, stg[j]), 32'(stall[j] > stg[j]), 32'd0);
      end
      ro_snap = r_ready_o;
      r_ready = ~r_ready;
      #1;
      check($sformatf("rnd%0d.ready_o_comb_path", cyc), 32'(r_ready_o), 32'(ro_snap));
      r_ready = ~r_ready;
      #1;
      in_x  = r_valid & r_ready_o;
      out_x = r_valid_o & r_ready;
      @(posedge clk);
      for (int j = 0; j < 2; j++) begin
        if (r_flush[j]) q[j].delete();
        else begin
          if (out_x[j] && q[j].size() > 0) void'(q[j].pop_front());
          if (in_x[j]) q[j].push_back(r_data[j]);
        end
      end
      prev_fl = r_flush;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
